// File: rtl/ahbl_uart_tx_if.sv
// AHB-Lite slave bus bundle for the UART transmitter.
// The slave modport receives the address/data phase signals and drives HREADYOUT/HRDATA.
interface ahbl_uart_tx_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic        HWRITE;
    logic        HREADY;
    logic [31:0] HWDATA;
    logic        HREADYOUT;
    logic [31:0] HRDATA;

    modport master (
        output HSEL, HADDR, HTRANS, HSIZE, HWRITE, HREADY, HWDATA,
        input  HREADYOUT, HRDATA
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HSIZE, HWRITE, HREADY, HWDATA,
        output HREADYOUT, HRDATA
    );
endinterface

// File: rtl/ahbl_uart_tx.sv
// AHB-Lite UART transmitter: register file, TX FIFO and 8N1 serialiser.
// Latency: a DATA write completes at its data-phase edge; the frame start bit drives one edge later.
// Backpressure: none on the bus (zero wait states); writes to a full FIFO are dropped and flag overflow.

module ahbl_uart_tx_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned LW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop_vld,
    output logic [WIDTH-1:0] head_dat,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count_q == LW'(DEPTH));
    assign empty    = (count_q == '0);
    assign level    = count_q;
    assign head_dat = mem_q[rd_ptr_q];

    // Full is taken from the registered count, so a push is refused even if a pop lands on the same edge.
    always_comb begin
        push_ok  = push_vld & ~full;
        pop_ok   = pop_vld & ~empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + LW'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - LW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end
endmodule

module ahbl_uart_tx #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [15:0] BAUD_RESET = 16'd434
) (
    input  logic            HCLK,
    input  logic            HRESET,
    ahbl_uart_tx_if.slave   ahb,
    output logic            TXD,
    output logic            IRQ
);
    localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of 2 in 2..16");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    localparam logic [1:0] R_DATA = 2'd0;
    localparam logic [1:0] R_STAT = 2'd1;
    localparam logic [1:0] R_BAUD = 2'd2;
    localparam logic [1:0] R_CTRL = 2'd3;

    logic          acc_vld_q, acc_vld_d;
    logic          acc_wr_q, acc_wr_d;
    logic [1:0]    acc_addr_q, acc_addr_d;
    logic [15:0]   baud_div_q, baud_div_d;
    logic          ctrl_en_q, ctrl_en_d;
    logic          ctrl_ie_q, ctrl_ie_d;
    logic          ovf_q, ovf_d;

    state_t        state_q;
    logic          txd_q;
    logic [15:0]   baud_cnt_q;
    logic [2:0]    bit_idx_q;
    logic [7:0]    shift_q;

    logic          wr_en;
    logic          fifo_push;
    logic          tx_pop;
    logic [7:0]    fifo_head;
    logic          fifo_full;
    logic          fifo_empty;
    logic [LW-1:0] fifo_level;
    logic          busy;
    logic [31:0]   status_word;
    logic          unused_bits;

    assign unused_bits = ^{ahb.HSIZE, ahb.HADDR[31:4], ahb.HADDR[1:0], ahb.HWDATA[31:16]};

    ahbl_uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk      (HCLK),
        .rst      (HRESET),
        .push_vld (fifo_push),
        .push_dat (ahb.HWDATA[7:0]),
        .pop_vld  (tx_pop),
        .head_dat (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (fifo_level)
    );

    assign wr_en     = acc_vld_q & acc_wr_q;
    assign fifo_push = wr_en & (acc_addr_q == R_DATA);
    assign tx_pop    = (state_q == S_IDLE) & ctrl_en_q & ~fifo_empty;
    assign busy      = (state_q != S_IDLE);

    // The address phase is held while another slave stalls the bus.
    always_comb begin
        acc_vld_d  = acc_vld_q;
        acc_wr_d   = acc_wr_q;
        acc_addr_d = acc_addr_q;
        if (ahb.HREADY) begin
            acc_vld_d  = ahb.HSEL & ahb.HTRANS[1];
            acc_wr_d   = ahb.HWRITE;
            acc_addr_d = ahb.HADDR[3:2];
        end
    end

    always_comb begin
        baud_div_d = baud_div_q;
        ctrl_en_d  = ctrl_en_q;
        ctrl_ie_d  = ctrl_ie_q;
        ovf_d      = ovf_q;
        if (wr_en) begin
            case (acc_addr_q)
                R_DATA: if (fifo_full) ovf_d = 1'b1;
                R_STAT: if (ahb.HWDATA[3]) ovf_d = 1'b0;
                R_BAUD: baud_div_d = ahb.HWDATA[15:0];
                R_CTRL: begin
                    ctrl_en_d = ahb.HWDATA[0];
                    ctrl_ie_d = ahb.HWDATA[1];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            acc_vld_q  <= 1'b0;
            acc_wr_q   <= 1'b0;
            acc_addr_q <= R_DATA;
            baud_div_q <= BAUD_RESET;
            ctrl_en_q  <= 1'b0;
            ctrl_ie_q  <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            acc_vld_q  <= acc_vld_d;
            acc_wr_q   <= acc_wr_d;
            acc_addr_q <= acc_addr_d;
            baud_div_q <= baud_div_d;
            ctrl_en_q  <= ctrl_en_d;
            ctrl_ie_q  <= ctrl_ie_d;
            ovf_q      <= ovf_d;
        end
    end

    // Each bit lasts baud_div+1 cycles; the counter reloads at every bit boundary.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q    <= S_IDLE;
            txd_q      <= 1'b1;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    txd_q <= 1'b1;
                    if (tx_pop) begin
                        shift_q    <= fifo_head;
                        txd_q      <= 1'b0;
                        baud_cnt_q <= baud_div_q;
                        state_q    <= S_START;
                    end
                end
                S_START: begin
                    if (baud_cnt_q == '0) begin
                        txd_q      <= shift_q[0];
                        shift_q    <= shift_q >> 1;
                        bit_idx_q  <= '0;
                        baud_cnt_q <= baud_div_q;
                        state_q    <= S_DATA;
                    end else begin
                        baud_cnt_q <= baud_cnt_q - 16'd1;
                    end
                end
                S_DATA: begin
                    if (baud_cnt_q == '0) begin
                        baud_cnt_q <= baud_div_q;
                        if (bit_idx_q == 3'd7) begin
                            txd_q   <= 1'b1;
                            state_q <= S_STOP;
                        end else begin
                            txd_q     <= shift_q[0];
                            shift_q   <= shift_q >> 1;
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q - 16'd1;
                    end
                end
                S_STOP: begin
                    txd_q <= 1'b1;
                    if (baud_cnt_q == '0) begin
                        state_q <= S_IDLE;
                    end else begin
                        baud_cnt_q <= baud_cnt_q - 16'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        status_word      = '0;
        status_word[0]   = fifo_full;
        status_word[1]   = fifo_empty;
        status_word[2]   = busy;
        status_word[3]   = ovf_q;
        status_word[8:4] = 5'(fifo_level);
    end

    always_comb begin
        ahb.HRDATA = '0;
        case (acc_addr_q)
            R_STAT:  ahb.HRDATA = status_word;
            R_BAUD:  ahb.HRDATA = {16'h0, baud_div_q};
            R_CTRL:  ahb.HRDATA = {30'h0, ctrl_ie_q, ctrl_en_q};
            default: ahb.HRDATA = '0;
        endcase
    end

    assign ahb.HREADYOUT = 1'b1;
    assign TXD           = txd_q;
    assign IRQ           = ctrl_ie_q & fifo_empty;
endmodule

// File: tb/tb_ahbl_uart_tx.sv
// Directed bench for ahbl_uart_tx: register access, framing, FIFO overflow, reset and streaming.
module tb_ahbl_uart_tx;
    localparam int unsigned DEPTH    = 8;
    localparam logic [15:0] BAUD_RST = 16'd434;
    localparam logic [3:0]  A_DATA   = 4'h0;
    localparam logic [3:0]  A_STAT   = 4'h4;
    localparam logic [3:0]  A_BAUD   = 4'h8;
    localparam logic [3:0]  A_CTRL   = 4'hC;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        TXD;
    logic        IRQ;
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] rd;
    logic [7:0]  rx_q [$];
    logic [7:0]  rx_byte;
    int          rx_cyc;

    ahbl_uart_tx_if bus ();

    ahbl_uart_tx #(
        .FIFO_DEPTH (DEPTH),
        .BAUD_RESET (BAUD_RST)
    ) dut (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .ahb    (bus),
        .TXD    (TXD),
        .IRQ    (IRQ)
    );

    always #5 HCLK = ~HCLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Returns 1ns after the data-phase edge of the write.
    task automatic ahb_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge HCLK);
        bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b1; bus.HADDR = {28'h0, a};
        @(negedge HCLK);
        bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HWRITE = 1'b0; bus.HWDATA = d;
        @(posedge HCLK);
        #1;
    endtask

    task automatic ahb_read(input logic [3:0] a, output logic [31:0] d);
        @(negedge HCLK);
        bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b0; bus.HADDR = {28'h0, a};
        @(posedge HCLK);
        #1;
        bus.HSEL = 1'b0; bus.HTRANS = 2'b00;
        d = bus.HRDATA;
    endtask

    // gap = idle-high cycles expected before the start bit.
    task automatic expect_frame(input logic [7:0] b, input int div, input int gap);
        logic [9:0] bits;
        bits = {1'b1, b, 1'b0};
        for (int g = 0; g < gap; g++) begin
            @(posedge HCLK); #1;
            check("gap_high", {31'h0, TXD}, 32'h1);
        end
        for (int k = 0; k < 10; k++) begin
            for (int c = 0; c <= div; c++) begin
                @(posedge HCLK); #1;
                check($sformatf("txd_%02h_bit%0d", b, k), {31'h0, TXD}, {31'h0, bits[k]});
            end
        end
    endtask

    task automatic expect_idle(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(posedge HCLK); #1;
            check("idle_high", {31'h0, TXD}, 32'h1);
        end
    endtask

    function automatic logic [7:0] sb(input int i);
        return 8'(i * 37 + 11);
    endfunction

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.HSEL = 1'b0; bus.HADDR = '0; bus.HTRANS = 2'b00; bus.HSIZE = 3'b010;
        bus.HWRITE = 1'b0; bus.HREADY = 1'b1; bus.HWDATA = '0;
        HRESET = 1'b1;

        // Reset state
        repeat (2) @(posedge HCLK);
        #1;
        check("rst_txd", {31'h0, TXD}, 32'h1);
        check("rst_irq", {31'h0, IRQ}, 32'h0);
        check("rst_hrdata", bus.HRDATA, 32'h0);
        check("rst_hreadyout", {31'h0, bus.HREADYOUT}, 32'h1);
        @(negedge HCLK);
        HRESET = 1'b0;
        ahb_read(A_STAT, rd); check("rst_status", rd, 32'h2);
        ahb_read(A_BAUD, rd); check("rst_baud", rd, {16'h0, BAUD_RST});
        ahb_read(A_CTRL, rd); check("rst_ctrl", rd, 32'h0);

        // Single 0xA5 frame at 4 cycles per bit
        ahb_write(A_BAUD, 32'h3);
        ahb_write(A_CTRL, 32'h1);
        ahb_read(A_BAUD, rd); check("baud_rb", rd, 32'h3);
        ahb_read(A_CTRL, rd); check("ctrl_rb", rd, 32'h1);
        ahb_read(A_DATA, rd); check("data_rd_zero", rd, 32'h0);
        ahb_write(A_DATA, 32'hFFFF_FFA5);
        expect_frame(8'hA5, 3, 0);
        ahb_read(A_STAT, rd); check("a5_status_idle", rd, 32'h2);

        // Overflow with EN=0, then drain 8 bytes in order
        ahb_write(A_CTRL, 32'h0);
        for (int i = 0; i < 9; i++) ahb_write(A_DATA, 32'h10 + i);
        ahb_read(A_STAT, rd); check("ovf_status", rd, 32'h89);
        ahb_write(A_STAT, 32'h8);
        ahb_read(A_STAT, rd); check("ovf_cleared", rd, 32'h81);
        ahb_write(A_BAUD, 32'h1);
        ahb_write(A_CTRL, 32'h1);
        expect_frame(8'h10, 1, 0);
        for (int i = 1; i < 8; i++) expect_frame(8'(8'h10 + i), 1, 1);
        expect_idle(6);
        ahb_read(A_STAT, rd); check("drain_status", rd, 32'h2);

        // Back-to-back frames at 1 cycle per bit
        ahb_write(A_BAUD, 32'h0);
        ahb_write(A_CTRL, 32'h0);
        ahb_write(A_DATA, 32'hC3);
        ahb_write(A_DATA, 32'h01);
        ahb_write(A_DATA, 32'h80);
        ahb_write(A_CTRL, 32'h1);
        fork
            begin
                expect_frame(8'hC3, 0, 0);
                expect_frame(8'h01, 0, 1);
                expect_frame(8'h80, 0, 1);
            end
            begin
                logic [31:0] r0;
                repeat (2) @(posedge HCLK);
                ahb_read(A_STAT, r0); check("b2b_status_lvl2", r0, 32'h24);
                repeat (21) @(posedge HCLK);
                ahb_read(A_STAT, r0); check("b2b_status_last", r0, 32'h6);
            end
        join
        ahb_read(A_STAT, rd); check("b2b_status_end", rd, 32'h2);

        // Reset in the third data bit
        ahb_write(A_BAUD, 32'h3);
        ahb_write(A_CTRL, 32'h0);
        ahb_write(A_DATA, 32'h00);
        ahb_write(A_DATA, 32'h33);
        ahb_write(A_CTRL, 32'h3);
        repeat (14) @(posedge HCLK);
        #1;
        check("pre_rst_bit2", {31'h0, TXD}, 32'h0);
        HRESET = 1'b1;
        #1;
        check("mid_rst_txd", {31'h0, TXD}, 32'h1);
        check("mid_rst_irq", {31'h0, IRQ}, 32'h0);
        check("mid_rst_hrdata", bus.HRDATA, 32'h0);
        check("mid_rst_hreadyout", {31'h0, bus.HREADYOUT}, 32'h1);
        @(negedge HCLK);
        HRESET = 1'b0;
        ahb_read(A_STAT, rd); check("post_rst_status", rd, 32'h2);
        ahb_read(A_BAUD, rd); check("post_rst_baud", rd, {16'h0, BAUD_RST});
        ahb_read(A_CTRL, rd); check("post_rst_ctrl", rd, 32'h0);
        ahb_write(A_CTRL, 32'h1);
        expect_idle(10);
        ahb_read(A_STAT, rd); check("post_rst_no_frame", rd, 32'h2);

        // IRQ timing around a single push/pop
        ahb_write(A_BAUD, 32'h0);
        ahb_write(A_CTRL, 32'h3);
        check("irq_empty", {31'h0, IRQ}, 32'h1);
        ahb_write(A_DATA, 32'h7E);
        check("irq_after_push", {31'h0, IRQ}, 32'h0);
        @(posedge HCLK); #1;
        check("irq_at_pop", {31'h0, IRQ}, 32'h1);
        repeat (12) @(posedge HCLK);

        // Stream 20 bytes through the FIFO so both pointers wrap
        ahb_write(A_CTRL, 32'h2);
        for (int i = 0; i < 8; i++) ahb_write(A_DATA, {24'h0, sb(i)});
        check("irq_nonempty", {31'h0, IRQ}, 32'h0);
        rx_q.delete();
        rx_cyc = 0;
        fork
            begin
                while (rx_q.size() < 20 && rx_cyc < 1000) begin
                    @(posedge HCLK); #1; rx_cyc++;
                    if (TXD == 1'b0) begin
                        for (int k = 0; k < 8; k++) begin
                            @(posedge HCLK); #1; rx_cyc++;
                            rx_byte[k] = TXD;
                        end
                        @(posedge HCLK); #1; rx_cyc++;
                        check("rx_stop", {31'h0, TXD}, 32'h1);
                        rx_q.push_back(rx_byte);
                    end
                end
            end
            begin
                ahb_write(A_CTRL, 32'h3);
                for (int i = 8; i < 20; i++) begin
                    repeat (10) @(posedge HCLK);
                    ahb_write(A_DATA, {24'h0, sb(i)});
                end
            end
        join
        check("rx_count", rx_q.size(), 32'd20);
        for (int i = 0; i < rx_q.size() && i < 20; i++) begin
            check($sformatf("stream_%0d", i), {24'h0, rx_q[i]}, {24'h0, sb(i)});
        end
        repeat (2) @(posedge HCLK);
        ahb_read(A_STAT, rd); check("stream_status", rd, 32'h2);
        check("stream_irq", {31'h0, IRQ}, 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
